// File: rtl/rtc_bus_pkg.sv
// Shared types and helpers for the RTC multiplexed AD-bus cycle engine.
// Holds the phase state machine encoding, pin bundle and phase-length clamp.
package rtc_bus_pkg;

  localparam int CNT_W = 4;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SETUP,
    S_A_STROBE,
    S_A_HOLD,
    S_GAP,
    S_D_SETUP,
    S_D_STROBE,
    S_D_HOLD,
    S_DONE
  } state_e;

  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_oe;
    logic       ad_sel;
    logic [7:0] ad_out;
    logic       busy;
    logic       done;
  } pins_t;

  // A zero-length phase would never expire, so it is stretched to one cycle.
  function automatic logic [CNT_W-1:0] clamp_len(input int t);
    if (t < 1) return CNT_W'(1);
    if (t > 15) return CNT_W'(15);
    return CNT_W'(t);
  endfunction

  // Bus pin levels for the cycles spent in state s.
  function automatic pins_t drive_pins(input state_e s, input logic rw,
                                       input logic [7:0] addr, input logic [7:0] wdata);
    pins_t p;
    p.cs_n   = 1'b1;
    p.rd_n   = 1'b1;
    p.wr_n   = 1'b1;
    p.ad_oe  = 1'b0;
    p.ad_sel = 1'b0;
    p.ad_out = 8'h00;
    p.busy   = 1'b1;
    p.done   = 1'b0;
    case (s)
      S_IDLE: p.busy = 1'b0;
      S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
        p.cs_n   = 1'b0;
        p.ad_oe  = 1'b1;
        p.ad_out = addr;
        p.wr_n   = (s != S_A_STROBE);
      end
      S_GAP: p.ad_out = addr;
      S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
        p.cs_n   = 1'b0;
        p.ad_sel = 1'b1;
        p.ad_oe  = (rw == WRITE);
        p.ad_out = wdata;
        if (s == S_D_STROBE) begin
          p.rd_n = (rw != READ);
          p.wr_n = (rw != WRITE);
        end
      end
      S_DONE: begin
        p.ad_sel = 1'b1;
        p.ad_out = wdata;
        p.done   = 1'b1;
      end
      default: p.busy = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rtc_bus_cycle_timer.sv
// Phase timer: 4-bit down-counter loaded with the length of the phase being entered.
// expire_o marks the last cycle of the current phase.
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  state_e state_i,
  output logic   expire_o
);

  localparam logic [CNT_W-1:0] LEN_SETUP = clamp_len(T_SETUP);
  localparam logic [CNT_W-1:0] LEN_PULSE = clamp_len(T_PULSE);
  localparam logic [CNT_W-1:0] LEN_HOLD  = clamp_len(T_HOLD);
  localparam logic [CNT_W-1:0] LEN_GAP   = clamp_len(T_GAP);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] load_val;

  always_comb begin
    load_val = CNT_W'(1);
    case (state_i)
      S_A_SETUP, S_D_SETUP:   load_val = LEN_SETUP;
      S_A_STROBE, S_D_STROBE: load_val = LEN_PULSE;
      S_A_HOLD, S_D_HOLD:     load_val = LEN_HOLD;
      S_GAP:                  load_val = LEN_GAP;
      default:                load_val = CNT_W'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val;
    end else if (count_q > CNT_W'(1)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign expire_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/rtc_bus_cycle.sv
// RTC bus-cycle engine: one address phase then one data phase on the multiplexed
// AD bus per accepted request; read bytes are returned tagged with their address.
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       RW,
  input  logic [7:0] address,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] rdata_addr,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       ad_sel,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n
);

  state_e     state_q, state_d;
  logic       load;
  logic       expire;
  logic       accept;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_addr_q;
  pins_t      pins_q;

  rtc_phase_timer #(
    .T_SETUP(T_SETUP),
    .T_PULSE(T_PULSE),
    .T_HOLD (T_HOLD),
    .T_GAP  (T_GAP)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .state_i (state_d),
    .expire_o(expire)
  );

  assign accept  = (state_q == S_IDLE) && start;
  assign rw_d    = accept ? RW      : rw_q;
  assign addr_d  = accept ? address : addr_q;
  assign wdata_d = accept ? wdata   : wdata_q;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE:     if (start) state_d = S_A_SETUP;
      S_A_SETUP:  if (expire) state_d = S_A_STROBE;
      S_A_STROBE: if (expire) state_d = S_A_HOLD;
      S_A_HOLD:   if (expire) state_d = S_GAP;
      S_GAP:      if (expire) state_d = S_D_SETUP;
      S_D_SETUP:  if (expire) state_d = S_D_STROBE;
      S_D_STROBE: if (expire) state_d = S_D_HOLD;
      S_D_HOLD:   if (expire) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (state_d != state_q) load = 1'b1;
  end

  // Pins are registered from the state being entered, so every bus output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rw_q         <= READ;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      rdata_q      <= 8'h00;
      rdata_addr_q <= 8'h00;
      pins_q       <= drive_pins(S_IDLE, READ, 8'h00, 8'h00);
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pins_q  <= drive_pins(state_d, rw_d, addr_d, wdata_d);
      if ((state_q == S_D_STROBE) && expire && (rw_q == READ)) begin
        rdata_q      <= ad_in;
        rdata_addr_q <= addr_q;
      end
    end
  end

  assign busy       = pins_q.busy;
  assign done       = pins_q.done;
  assign cs_n       = pins_q.cs_n;
  assign rd_n       = pins_q.rd_n;
  assign wr_n       = pins_q.wr_n;
  assign ad_oe      = pins_q.ad_oe;
  assign ad_sel     = pins_q.ad_sel;
  assign ad_out     = pins_q.ad_out;
  assign rdata      = rdata_q;
  assign rdata_addr = rdata_addr_q;

endmodule
